// File: rtl/issue_pkg.sv
// Shared definitions for the convolution front end (issue block).
//   state_e  : scanner FSM states
//   COORD_W  : pixel coordinate width (x, y)
//   DEPTH_W  : channel index / channel count width
//   BOUND_W  : width used for window bounds so that c + hs never wraps at image_dim = 255
package issue_pkg;

  localparam int COORD_W = 8;
  localparam int DEPTH_W = 9;
  localparam int BOUND_W = 9;

  typedef enum logic [1:0] {
    IDLE,
    ASSIGN,
    ISSUE,
    DONE
  } state_e;

endpackage

// File: rtl/issue_imem.sv
// Image memory: simple dual-port RAM, port A write-only, port B read-only with a
// one-cycle synchronous read.
//   clk, rst        : clock, asynchronous active-high reset (read register only)
//   wr_en/addr/data : port A write
//   rd_en, rd_addr  : port B read request
//   rd_data         : registered read data, zero on cycles without a read
module issue_imem #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rd_data_q;

  // NOTE: the storage array has no reset on purpose: it must survive rst, and a
  // reset on every word would prevent mapping onto a RAM macro.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  // Returning zero on idle cycles keeps issue_data quiet outside issue_en.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        rd_data_q <= '0;
    else if (rd_en) rd_data_q <= mem_q[rd_addr];
    else            rd_data_q <= '0;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/issue.sv
// Convolution front end: scans filter centres over the stored image, deals them
// round-robin to allocators, then streams every pixel of the round's bounding box.
//   clk, rst                   : clock, asynchronous active-high reset
//   imem_write_*_a             : loader write port into the image memory
//   image_dim, image_depth     : image width/height and channel count (stable while running)
//   filter_halfsize            : window half-width hs
//   filter_stride              : centre step (0 behaves as 1)
//   issue_x/y/z/data, issue_en : registered pixel stream
//   issue_block                : per-allocator stall request (only active allocators count)
//   positioner_x/y/select      : centre assignment, one-hot one-cycle select
//   done                       : sticky end-of-scan flag
module issue
  import issue_pkg::*;
#(
  parameter int num_allocators = 2,
  parameter int IMEM_ADDR_W    = 12,
  parameter int DATA_W         = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [IMEM_ADDR_W-1:0]    imem_write_addr_a,
  input  logic [DATA_W-1:0]         imem_write_data_a,
  input  logic                      imem_write_en_a,
  input  logic [COORD_W-1:0]        image_dim,
  input  logic [DEPTH_W-1:0]        image_depth,
  input  logic [1:0]                filter_halfsize,
  input  logic [2:0]                filter_stride,
  output logic [COORD_W-1:0]        issue_x,
  output logic [COORD_W-1:0]        issue_y,
  output logic [DEPTH_W-1:0]        issue_z,
  output logic [DATA_W-1:0]         issue_data,
  output logic                      issue_en,
  input  logic [num_allocators-1:0] issue_block,
  output logic [COORD_W-1:0]        positioner_x,
  output logic [COORD_W-1:0]        positioner_y,
  output logic [num_allocators-1:0] positioner_select,
  output logic                      done
);

  localparam int K_W = (num_allocators > 1) ? $clog2(num_allocators) : 1;

  // State
  state_e                    state_q, state_d;
  logic [BOUND_W-1:0]        cx_q, cx_d, cy_q, cy_d;
  logic [K_W-1:0]            k_q, k_d;
  logic [num_allocators-1:0] mask_q, mask_d;
  logic [BOUND_W-1:0]        min_x_q, min_x_d, max_x_q, max_x_d;
  logic [BOUND_W-1:0]        min_y_q, min_y_d, max_y_q, max_y_d;
  logic                      more_q, more_d;
  logic [BOUND_W-1:0]        rx_q, rx_d, ry_q, ry_d;
  logic [DEPTH_W-1:0]        rz_q, rz_d;
  logic [IMEM_ADDR_W-1:0]    addr_q, addr_d, row_addr_q, row_addr_d;

  // Registered outputs
  logic [COORD_W-1:0]        issue_x_q, issue_x_d, issue_y_q, issue_y_d;
  logic [DEPTH_W-1:0]        issue_z_q, issue_z_d;
  logic                      issue_en_q, issue_en_d;
  logic [COORD_W-1:0]        pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic [num_allocators-1:0] sel_q, sel_d;
  logic                      done_q, done_d;
  logic                      rd_en;

  // Configuration-derived values, all in BOUND_W bits
  logic [BOUND_W-1:0]     hs_b, stride_b, dim_b, dim_m1;
  logic [DEPTH_W-1:0]     depth_m1;
  logic                   any_pos;
  logic [IMEM_ADDR_W-1:0] row_step;

  assign hs_b     = BOUND_W'(filter_halfsize);
  assign stride_b = (filter_stride == 3'd0) ? BOUND_W'(1) : BOUND_W'(filter_stride);
  assign dim_b    = BOUND_W'(image_dim);
  assign dim_m1   = dim_b - BOUND_W'(1);
  assign depth_m1 = image_depth - DEPTH_W'(1);
  assign any_pos  = (hs_b + hs_b + BOUND_W'(1)) <= dim_b;
  assign row_step = IMEM_ADDR_W'(32'(image_dim) * 32'(image_depth));

  // Centre scan helpers
  logic [BOUND_W-1:0]        nx, ny;
  logic                      x_fits, y_fits, last_centre, first, round_full;
  logic [num_allocators-1:0] k_onehot;
  logic [BOUND_W-1:0]        min_x_new, max_x_new, min_y_new, max_y_new;

  assign nx          = cx_q + stride_b;
  assign ny          = cy_q + stride_b;
  assign x_fits      = (nx + hs_b) <= dim_m1;
  assign y_fits      = (ny + hs_b) <= dim_m1;
  assign last_centre = !x_fits && !y_fits;
  assign first       = (k_q == '0);
  assign round_full  = (k_q == K_W'(num_allocators - 1));
  assign k_onehot    = num_allocators'(1) << k_q;

  // Round bounding box of centres, including the centre being assigned now.
  // A new round discards the previous round's extremes.
  assign min_x_new = (first || cx_q < min_x_q) ? cx_q : min_x_q;
  assign max_x_new = (first || cx_q > max_x_q) ? cx_q : max_x_q;
  assign min_y_new = (first || cy_q < min_y_q) ? cy_q : min_y_q;
  assign max_y_new = (first || cy_q > max_y_q) ? cy_q : max_y_q;

  // Issue box helpers
  logic [BOUND_W-1:0]     x_lo, x_hi, y_hi, rx_start, ry_start;
  logic [IMEM_ADDR_W-1:0] start_addr;
  logic                   stall;

  assign x_lo       = min_x_q - hs_b;
  assign x_hi       = max_x_q + hs_b;
  assign y_hi       = max_y_q + hs_b;
  assign rx_start   = min_x_new - hs_b;
  assign ry_start   = min_y_new - hs_b;
  // Only the box corner needs a full multiply; every later address is incremental.
  assign start_addr = IMEM_ADDR_W'((32'(ry_start) * 32'(image_dim) + 32'(rx_start))
                                   * 32'(image_depth));
  assign stall      = |(issue_block & mask_q);

  // NOTE: every signal written below gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    cx_d       = cx_q;
    cy_d       = cy_q;
    k_d        = k_q;
    mask_d     = mask_q;
    min_x_d    = min_x_q;
    max_x_d    = max_x_q;
    min_y_d    = min_y_q;
    max_y_d    = max_y_q;
    more_d     = more_q;
    rx_d       = rx_q;
    ry_d       = ry_q;
    rz_d       = rz_q;
    addr_d     = addr_q;
    row_addr_d = row_addr_q;
    issue_x_d  = '0;
    issue_y_d  = '0;
    issue_z_d  = '0;
    issue_en_d = 1'b0;
    pos_x_d    = '0;
    pos_y_d    = '0;
    sel_d      = '0;
    done_d     = done_q;
    rd_en      = 1'b0;

    unique case (state_q)
      IDLE: begin
        // The scan start tracks hs here rather than in reset, so reset stays a constant.
        cx_d   = hs_b;
        cy_d   = hs_b;
        k_d    = '0;
        mask_d = '0;
        if (!imem_write_en_a) begin
          if (any_pos) state_d = ASSIGN;
          else begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end

      ASSIGN: begin
        pos_x_d = cx_q[COORD_W-1:0];
        pos_y_d = cy_q[COORD_W-1:0];
        sel_d   = k_onehot;
        mask_d  = (first ? '0 : mask_q) | k_onehot;
        min_x_d = min_x_new;
        max_x_d = max_x_new;
        min_y_d = min_y_new;
        max_y_d = max_y_new;
        if (x_fits) begin
          cx_d = nx;
        end else if (y_fits) begin
          cx_d = hs_b;
          cy_d = ny;
        end
        if (last_centre || round_full) begin
          state_d    = ISSUE;
          more_d     = !last_centre;
          k_d        = '0;
          rx_d       = rx_start;
          ry_d       = ry_start;
          rz_d       = '0;
          addr_d     = start_addr;
          row_addr_d = start_addr;
        end else begin
          k_d = k_q + K_W'(1);
        end
      end

      ISSUE: begin
        if (!stall) begin
          rd_en      = 1'b1;
          issue_en_d = 1'b1;
          issue_x_d  = rx_q[COORD_W-1:0];
          issue_y_d  = ry_q[COORD_W-1:0];
          issue_z_d  = rz_q;
          // Channels of one row are contiguous, so the address steps by one
          // until the row of the box ends.
          if (rz_q != depth_m1) begin
            rz_d   = rz_q + DEPTH_W'(1);
            addr_d = addr_q + IMEM_ADDR_W'(1);
          end else if (rx_q != x_hi) begin
            rz_d   = '0;
            rx_d   = rx_q + BOUND_W'(1);
            addr_d = addr_q + IMEM_ADDR_W'(1);
          end else if (ry_q != y_hi) begin
            rz_d       = '0;
            rx_d       = x_lo;
            ry_d       = ry_q + BOUND_W'(1);
            row_addr_d = row_addr_q + row_step;
            addr_d     = row_addr_q + row_step;
          end else begin
            rz_d = '0;
            if (more_q) state_d = ASSIGN;
            else begin
              state_d = DONE;
              done_d  = 1'b1;
            end
          end
        end
      end

      DONE: begin
        done_d = 1'b1;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the values computed before the edge regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cx_q       <= '0;
      cy_q       <= '0;
      k_q        <= '0;
      mask_q     <= '0;
      min_x_q    <= '0;
      max_x_q    <= '0;
      min_y_q    <= '0;
      max_y_q    <= '0;
      more_q     <= 1'b0;
      rx_q       <= '0;
      ry_q       <= '0;
      rz_q       <= '0;
      addr_q     <= '0;
      row_addr_q <= '0;
      issue_x_q  <= '0;
      issue_y_q  <= '0;
      issue_z_q  <= '0;
      issue_en_q <= 1'b0;
      pos_x_q    <= '0;
      pos_y_q    <= '0;
      sel_q      <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cx_q       <= cx_d;
      cy_q       <= cy_d;
      k_q        <= k_d;
      mask_q     <= mask_d;
      min_x_q    <= min_x_d;
      max_x_q    <= max_x_d;
      min_y_q    <= min_y_d;
      max_y_q    <= max_y_d;
      more_q     <= more_d;
      rx_q       <= rx_d;
      ry_q       <= ry_d;
      rz_q       <= rz_d;
      addr_q     <= addr_d;
      row_addr_q <= row_addr_d;
      issue_x_q  <= issue_x_d;
      issue_y_q  <= issue_y_d;
      issue_z_q  <= issue_z_d;
      issue_en_q <= issue_en_d;
      pos_x_q    <= pos_x_d;
      pos_y_q    <= pos_y_d;
      sel_q      <= sel_d;
      done_q     <= done_d;
    end
  end

  // The read address is the current counter, so the registered RAM output lines
  // up with the registered issue_x/y/z/en of the same word.
  issue_imem #(
    .ADDR_W (IMEM_ADDR_W),
    .DATA_W (DATA_W)
  ) u_imem (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (imem_write_en_a),
    .wr_addr (imem_write_addr_a),
    .wr_data (imem_write_data_a),
    .rd_en   (rd_en),
    .rd_addr (addr_q),
    .rd_data (issue_data)
  );

  assign issue_x           = issue_x_q;
  assign issue_y           = issue_y_q;
  assign issue_z           = issue_z_q;
  assign issue_en          = issue_en_q;
  assign positioner_x      = pos_x_q;
  assign positioner_y      = pos_y_q;
  assign positioner_select = sel_q;
  assign done              = done_q;

endmodule

// File: tb/tb_issue.sv
`timescale 1ns/1ps
module tb_issue;

  localparam int N  = 2;
  localparam int AW = 12;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] wa = '0;
  logic [DW-1:0] wd = '0;
  logic          we = 1'b0;
  logic [7:0]    image_dim = '0;
  logic [8:0]    image_depth = '0;
  logic [1:0]    hs_in = '0;
  logic [2:0]    stride_in = '0;
  logic [7:0]    issue_x, issue_y;
  logic [8:0]    issue_z;
  logic [DW-1:0] issue_data;
  logic          issue_en;
  logic [N-1:0]  issue_block = '0;
  logic [7:0]    pos_x, pos_y;
  logic [N-1:0]  pos_sel;
  logic          done;

  always #5 clk = ~clk;

  issue #(.num_allocators(N), .IMEM_ADDR_W(AW), .DATA_W(DW)) dut (
    .clk               (clk),
    .rst               (rst),
    .imem_write_addr_a (wa),
    .imem_write_data_a (wd),
    .imem_write_en_a   (we),
    .image_dim         (image_dim),
    .image_depth       (image_depth),
    .filter_halfsize   (hs_in),
    .filter_stride     (stride_in),
    .issue_x           (issue_x),
    .issue_y           (issue_y),
    .issue_z           (issue_z),
    .issue_data        (issue_data),
    .issue_en          (issue_en),
    .issue_block       (issue_block),
    .positioner_x      (pos_x),
    .positioner_y      (pos_y),
    .positioner_select (pos_sel),
    .done              (done)
  );

  // blk: 0 none, 1 random, 2 constant 2'b10, 3 five-cycle 2'b10 burst mid first box
  typedef struct {
    int dim; int depth; int hs; int stride;
    int blk; int load; int addr_data; int abort_at;
    int exp_centres; int exp_rounds; int exp_first_run;
  } cfg_t;

  typedef struct packed { logic [7:0] x; logic [7:0] y; logic [8:0] z; logic [DW-1:0] d; } word_t;
  typedef struct packed { logic [7:0] x; logic [7:0] y; logic [N-1:0] sel; } sel_t;

  cfg_t          cfgs [8];
  word_t         exp_words [$];
  sel_t          exp_sels [$];
  logic [DW-1:0] mem_model [4096];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name, input string why);
    n_checks++;
    n_errors++;
    $display("FAIL %s: %s (t=%0t)", name, why, $time);
  endtask

  // Reference model: enumerate centres in raster order, group them N at a time,
  // and list every (x, y, z) of each group's padded bounding box.
  task automatic build_model(input cfg_t c);
    int cxs[$];
    int cys[$];
    int s;
    s = (c.stride == 0) ? 1 : c.stride;
    exp_words.delete();
    exp_sels.delete();
    for (int y = c.hs; y + c.hs <= c.dim - 1; y += s)
      for (int x = c.hs; x + c.hs <= c.dim - 1; x += s) begin
        cxs.push_back(x);
        cys.push_back(y);
      end
    for (int r = 0; r < cxs.size(); r += N) begin
      int lo_x, hi_x, lo_y, hi_y;
      lo_x = 1000; hi_x = -1; lo_y = 1000; hi_y = -1;
      for (int k = 0; k < N && r + k < cxs.size(); k++) begin
        sel_t e;
        e.x = 8'(cxs[r+k]);
        e.y = 8'(cys[r+k]);
        e.sel = N'(1) << k;
        exp_sels.push_back(e);
        if (cxs[r+k] < lo_x) lo_x = cxs[r+k];
        if (cxs[r+k] > hi_x) hi_x = cxs[r+k];
        if (cys[r+k] < lo_y) lo_y = cys[r+k];
        if (cys[r+k] > hi_y) hi_y = cys[r+k];
      end
      for (int y = lo_y - c.hs; y <= hi_y + c.hs; y++)
        for (int x = lo_x - c.hs; x <= hi_x + c.hs; x++)
          for (int z = 0; z < c.depth; z++) begin
            word_t w;
            w.x = 8'(x);
            w.y = 8'(y);
            w.z = 9'(z);
            w.d = mem_model[(y * c.dim + x) * c.depth + z];
            exp_words.push_back(w);
          end
    end
  endtask

  // Monitor: compares every select pulse and issued word against the model,
  // and checks that a blocked cycle with an active allocator is followed by a gap.
  int           words_seen, sels_seen, rounds_seen, run_cur, first_run, px44, px2525;
  logic         first_closed, stall_pend, issued_in_round;
  logic [N-1:0] mask;

  always @(negedge clk) begin
    if (rst) begin
      words_seen = 0; sels_seen = 0; rounds_seen = 0; run_cur = 0; first_run = 0;
      px44 = 0; px2525 = 0; first_closed = 1'b0; stall_pend = 1'b0;
      issued_in_round = 1'b0; mask = '0;
    end else begin
      if (stall_pend) check("stall_gap", 64'(issue_en), 64'(0));
      if (pos_sel != '0) begin
        if (issued_in_round) begin
          mask = '0;
          issued_in_round = 1'b0;
        end
        mask |= pos_sel;
        sels_seen++;
        if (pos_sel == N'(1)) rounds_seen++;
        if (exp_sels.size() == 0) fail("extra_select", "select pulse beyond the last centre");
        else begin
          sel_t e;
          e = exp_sels.pop_front();
          check("select", 64'({pos_x, pos_y, pos_sel}), 64'(e));
        end
      end
      if (issue_en) begin
        issued_in_round = 1'b1;
        words_seen++;
        run_cur++;
        if (issue_x == 8'd4 && issue_y == 8'd4) px44++;
        if (issue_x == 8'd25 && issue_y == 8'd25) px2525++;
        if (exp_words.size() == 0) fail("extra_word", "issue_en beyond the last word");
        else begin
          word_t w;
          w = exp_words.pop_front();
          check("word", 64'({issue_x, issue_y, issue_z, issue_data}), 64'(w));
        end
      end else if (run_cur > 0 && !first_closed) begin
        first_run = run_cur;
        first_closed = 1'b1;
      end
      stall_pend = (issue_block & mask) != '0;
    end
  end

  task automatic run_cfg(input int idx);
    cfg_t c;
    int   cyc;
    logic burst_done;
    c = cfgs[idx];
    burst_done = 1'b0;
    rst = 1'b1;
    we = 1'b0;
    issue_block = '0;
    image_dim = 8'(c.dim);
    image_depth = 9'(c.depth);
    hs_in = 2'(c.hs);
    stride_in = 3'(c.stride);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    if (c.load != 0) begin
      for (int a = 0; a < c.dim * c.dim * c.depth; a++) begin
        logic [DW-1:0] d;
        d = (c.addr_data != 0) ? DW'(a) : DW'($urandom);
        we = 1'b1;
        wa = AW'(a);
        wd = d;
        mem_model[a] = d;
        @(posedge clk);
        #1;
      end
      we = 1'b0;
    end
    build_model(c);

    cyc = 0;
    while (!done && cyc < 30000) begin
      @(posedge clk);
      #1;
      cyc++;
      case (c.blk)
        1: issue_block = N'($urandom);
        2: issue_block = N'(2);
        default: issue_block = '0;
      endcase
      if (c.blk == 3 && !burst_done && words_seen >= 60) begin
        burst_done = 1'b1;
        issue_block = N'(2);
        for (int i = 0; i < 5; i++) begin
          @(posedge clk);
          #1;
          cyc++;
          if (i == 4) issue_block = '0;
          @(negedge clk);
          check("burst_gap", 64'(issue_en), 64'(0));
        end
        @(posedge clk);
        #1;
        cyc++;
        @(negedge clk);
        check("burst_resume", 64'(issue_en), 64'(1));
      end
      if (c.abort_at > 0 && words_seen >= c.abort_at) begin
        rst = 1'b1;
        #1;
        check("abort_outputs",
              64'({issue_x, issue_y, issue_z, issue_data, issue_en, pos_x, pos_y, pos_sel, done}),
              64'(0));
        exp_words.delete();
        exp_sels.delete();
        issue_block = '0;
        @(negedge clk);
        return;
      end
    end
    issue_block = '0;
    if (!done) fail("done_timeout", $sformatf("cfg %0d did not finish", idx));
    if (c.exp_centres == 0) check("done_latency", 64'(cyc <= 2), 64'(1));
    repeat (3) @(negedge clk);
    check("done_sticky", 64'(done), 64'(1));
    check("done_quiet",
          64'({issue_en, issue_data, issue_x, issue_y, issue_z, pos_x, pos_y, pos_sel}), 64'(0));
    check("words_left", 64'(exp_words.size()), 64'(0));
    check("centres", 64'(sels_seen), 64'(c.exp_centres));
    check("rounds", 64'(rounds_seen), 64'(c.exp_rounds));
    if (c.exp_first_run != 0) check("first_run", 64'(first_run), 64'(c.exp_first_run));
    if (c.addr_data != 0) begin
      check("pixel_4_4_count", 64'(px44), 64'(6));
      check("pixel_25_25_count", 64'(px2525), 64'(0));
    end
  endtask

  initial begin
    //          dim dep hs  s  blk ld ad abort cen rnd run
    cfgs[0] = '{26,  3,  2, 4,  0, 1, 1,   0,  36, 18, 135};
    cfgs[1] = '{26,  3,  2, 4,  3, 0, 0,   0,  36, 18,   0};
    cfgs[2] = '{26,  3,  2, 4,  1, 0, 0, 300,   0,  0,   0};
    cfgs[3] = '{26,  3,  2, 4,  0, 0, 0,   0,  36, 18, 135};
    cfgs[4] = '{ 4,  1,  2, 1,  0, 0, 0,   0,   0,  0,   0};
    cfgs[5] = '{ 5,  2,  2, 0,  2, 1, 0,   0,   1,  1,  50};
    cfgs[6] = '{ 7,  1,  1, 0,  1, 1, 0,   0,  25, 13,   0};
    cfgs[7] = '{ 9,  2,  1, 3,  1, 1, 0,   0,   9,  5,   0};

    repeat (2) @(negedge clk);
    check("reset_outputs",
          64'({issue_x, issue_y, issue_z, issue_data, issue_en, pos_x, pos_y, pos_sel, done}),
          64'(0));
    for (int i = 0; i < 8; i++) run_cfg(i);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
